// File: rtl/jahangir_pkg.sv
// Shared types for the MIPS32 memory-access stage: op codes, FSM states and
// op classification helpers.
package jahangir_pkg;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      LB       = 4'd1,
      LBU      = 4'd2,
      LH       = 4'd3,
      LHU      = 4'd4,
      LW       = 4'd5,
      SB       = 4'd6,
      SH       = 4'd7,
      SW       = 4'd8
   } mem_op_t;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   function automatic logic is_mem(mem_op_t op);
      return op inside {LB, LBU, LH, LHU, LW, SB, SH, SW};
   endfunction

   function automatic logic is_store(mem_op_t op);
      return op inside {SB, SH, SW};
   endfunction

   // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
   function automatic logic is_misaligned(mem_op_t op, logic [1:0] lo);
      case (op)
         LH, LHU, SH: return lo[0];
         LW, SW:      return lo != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port between the memory stage (master) and the data memory (slave).
interface mem_stage_if #(
   parameter int ADDR_W = 32
);
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [3:0]        dm_be;
   logic [31:0]       dm_wdata;
   logic              dm_ack;
   logic [31:0]       dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
      output dm_ack, dm_rdata
   );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for stores and lane extraction with
// sign/zero extension for loads.
module mem_lane_align
   import jahangir_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   assign lane_byte = rdata[{addr_lo, 3'b000} +: 8];
   assign lane_half = rdata[{addr_lo[1], 4'b0000} +: 16];

   // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      be        = 4'hF;
      wdata     = '0;
      load_data = '0;
      case (op)
         SB: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         SH: begin
            be    = 4'b0011 << addr_lo;
            wdata = {2{store_data[15:0]}};
         end
         SW:      wdata     = store_data;
         LB:      load_data = {{24{lane_byte[7]}}, lane_byte};
         LBU:     load_data = {24'd0, lane_byte};
         LH:      load_data = {{16{lane_half[15]}}, lane_half};
         LHU:     load_data = {16'd0, lane_half};
         LW:      load_data = rdata;
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory-access pipeline stage: issues loads/stores over a req/ack port,
// stalls upstream while a request is outstanding, and guards it with an ack watchdog.
module mem_stage
   import jahangir_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_mem_op,
   input  logic [ADDR_W-1:0]     in_mem_addr,
   input  logic [31:0]           in_store_data,
   input  logic [31:0]           in_wr_data,
   input  logic [REG_ADDR_W-1:0] in_wr_address,
   input  logic                  in_wr_enable,
   mem_stage_if.master           dm,
   output logic                  out_valid,
   output logic [31:0]           out_wr_data,
   output logic [REG_ADDR_W-1:0] out_wr_address,
   output logic                  out_wr_enable,
   output logic                  exc_misaligned,
   output logic                  exc_bus_err
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t                  state_q, state_d;
   mem_op_t                 op_q, op_d;
   logic [1:0]              lane_q, lane_d;
   logic [REG_ADDR_W-1:0]   dest_q, dest_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    dm_req_q, dm_req_d, dm_we_q, dm_we_d;
   logic [ADDR_W-1:0]       dm_addr_q, dm_addr_d;
   logic [3:0]              dm_be_q, dm_be_d;
   logic [31:0]             dm_wdata_q, dm_wdata_d;
   logic                    out_valid_q, out_valid_d, out_wr_enable_q, out_wr_enable_d;
   logic [31:0]             out_wr_data_q, out_wr_data_d;
   logic [REG_ADDR_W-1:0]   out_wr_address_q, out_wr_address_d;
   logic                    exc_mis_q, exc_mis_d, exc_bus_q, exc_bus_d;

   mem_op_t     in_op, align_op;
   logic [1:0]  align_lo;
   logic [3:0]  align_be;
   logic [31:0] align_wdata, align_load;

   assign in_op = mem_op_t'(in_mem_op);

   // One aligner serves both phases: steering the incoming op in IDLE,
   // extracting the latched lane in ACCESS.
   assign align_op = (state_q == S_IDLE) ? in_op : op_q;
   assign align_lo = (state_q == S_IDLE) ? in_mem_addr[1:0] : lane_q;

   mem_lane_align u_align (
      .op         (align_op),
      .addr_lo    (align_lo),
      .store_data (in_store_data),
      .rdata      (dm.dm_rdata),
      .be         (align_be),
      .wdata      (align_wdata),
      .load_data  (align_load)
   );

   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      lane_d           = lane_q;
      dest_d           = dest_q;
      cnt_d            = cnt_q;
      dm_req_d         = dm_req_q;
      dm_we_d          = dm_we_q;
      dm_addr_d        = dm_addr_q;
      dm_be_d          = dm_be_q;
      dm_wdata_d       = dm_wdata_q;
      out_valid_d      = 1'b0;
      out_wr_enable_d  = 1'b0;
      out_wr_data_d    = out_wr_data_q;
      out_wr_address_d = out_wr_address_q;
      exc_mis_d        = 1'b0;
      exc_bus_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (!is_mem(in_op)) begin
                  out_valid_d      = 1'b1;
                  out_wr_data_d    = in_wr_data;
                  out_wr_address_d = in_wr_address;
                  out_wr_enable_d  = in_wr_enable & (in_wr_address != '0);
               end else if (is_misaligned(in_op, in_mem_addr[1:0])) begin
                  out_valid_d      = 1'b1;
                  out_wr_address_d = in_wr_address;
                  exc_mis_d        = 1'b1;
               end else begin
                  op_d       = in_op;
                  lane_d     = in_mem_addr[1:0];
                  dest_d     = in_wr_address;
                  cnt_d      = '0;
                  dm_req_d   = 1'b1;
                  dm_we_d    = is_store(in_op);
                  dm_addr_d  = {in_mem_addr[ADDR_W-1:2], 2'b00};
                  dm_be_d    = align_be;
                  dm_wdata_d = align_wdata;
                  state_d    = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            // An ack on the final watchdog cycle still completes the access.
            if (dm.dm_ack) begin
               dm_req_d         = 1'b0;
               out_valid_d      = 1'b1;
               out_wr_address_d = dest_q;
               if (!is_store(op_q)) begin
                  out_wr_data_d   = align_load;
                  out_wr_enable_d = (dest_q != '0);
               end
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               dm_req_d    = 1'b0;
               out_valid_d = 1'b1;
               exc_bus_d   = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         op_q             <= MEM_NONE;
         lane_q           <= '0;
         dest_q           <= '0;
         cnt_q            <= '0;
         dm_req_q         <= 1'b0;
         dm_we_q          <= 1'b0;
         dm_addr_q        <= '0;
         dm_be_q          <= '0;
         dm_wdata_q       <= '0;
         out_valid_q      <= 1'b0;
         out_wr_enable_q  <= 1'b0;
         out_wr_data_q    <= '0;
         out_wr_address_q <= '0;
         exc_mis_q        <= 1'b0;
         exc_bus_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         lane_q           <= lane_d;
         dest_q           <= dest_d;
         cnt_q            <= cnt_d;
         dm_req_q         <= dm_req_d;
         dm_we_q          <= dm_we_d;
         dm_addr_q        <= dm_addr_d;
         dm_be_q          <= dm_be_d;
         dm_wdata_q       <= dm_wdata_d;
         out_valid_q      <= out_valid_d;
         out_wr_enable_q  <= out_wr_enable_d;
         out_wr_data_q    <= out_wr_data_d;
         out_wr_address_q <= out_wr_address_d;
         exc_mis_q        <= exc_mis_d;
         exc_bus_q        <= exc_bus_d;
      end
   end

   assign in_ready       = (state_q == S_IDLE);
   assign dm.dm_req      = dm_req_q;
   assign dm.dm_we       = dm_we_q;
   assign dm.dm_addr     = dm_addr_q;
   assign dm.dm_be       = dm_be_q;
   assign dm.dm_wdata    = dm_wdata_q;
   assign out_valid      = out_valid_q;
   assign out_wr_data    = out_wr_data_q;
   assign out_wr_address = out_wr_address_q;
   assign out_wr_enable  = out_wr_enable_q;
   assign exc_misaligned = exc_mis_q;
   assign exc_bus_err    = exc_bus_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): passthrough, loads, stores,
// misalignment, watchdog, stray ack and reset during an access.
module tb_mem_stage;
   import jahangir_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_wr_enable;
   logic [3:0]  in_mem_op;
   logic [31:0] in_mem_addr, in_store_data, in_wr_data;
   logic [4:0]  in_wr_address;
   logic        out_valid, out_wr_enable, exc_misaligned, exc_bus_err;
   logic [31:0] out_wr_data;
   logic [4:0]  out_wr_address;

   int checks   = 0;
   int failures = 0;

   mem_stage_if #(.ADDR_W(32)) dm_if ();

   mem_stage #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_mem_op      (in_mem_op),
      .in_mem_addr    (in_mem_addr),
      .in_store_data  (in_store_data),
      .in_wr_data     (in_wr_data),
      .in_wr_address  (in_wr_address),
      .in_wr_enable   (in_wr_enable),
      .dm             (dm_if.master),
      .out_valid      (out_valid),
      .out_wr_data    (out_wr_data),
      .out_wr_address (out_wr_address),
      .out_wr_enable  (out_wr_enable),
      .exc_misaligned (exc_misaligned),
      .exc_bus_err    (exc_bus_err)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      in_valid      = 1'b0;
      in_mem_op     = MEM_NONE;
      in_mem_addr   = '0;
      in_store_data = '0;
      in_wr_data    = '0;
      in_wr_address = '0;
      in_wr_enable  = 1'b0;
   endtask

   task automatic drive_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] wdata, input logic [4:0] dest, input logic we);
      in_valid      = 1'b1;
      in_mem_op     = op;
      in_mem_addr   = addr;
      in_store_data = sdata;
      in_wr_data    = wdata;
      in_wr_address = dest;
      in_wr_enable  = we;
   endtask

   task automatic test_reset();
      logic [6:0] flags;
      rst_n = 1'b0;
      drive_idle();
      dm_if.dm_ack   = 1'b0;
      dm_if.dm_rdata = '0;
      step();
      step();
      rst_n = 1'b1;
      flags = {in_ready, dm_if.dm_req, dm_if.dm_we, out_valid, out_wr_enable, exc_misaligned, exc_bus_err};
      checks++;
      if (flags !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected %b", flags, 7'b1000000);
      end
      checks++;
      if ({dm_if.dm_addr, dm_if.dm_be, dm_if.dm_wdata, out_wr_data, out_wr_address} !== '0) begin
         failures++;
         $display("FAIL reset_data: addr=%h be=%h wdata=%h out=%h dest=%0d expected all zero",
                  dm_if.dm_addr, dm_if.dm_be, dm_if.dm_wdata, out_wr_data, out_wr_address);
      end
   endtask

   task automatic test_passthrough();
      drive_op(MEM_NONE, 32'h0, 32'h0, 32'h1234_5678, 5'd3, 1'b1);
      step();
      drive_idle();
      checks++;
      if ({out_valid, out_wr_data, out_wr_address, out_wr_enable} !== {1'b1, 32'h1234_5678, 5'd3, 1'b1}) begin
         failures++;
         $display("FAIL pass_r3: got v=%b d=%h a=%0d e=%b expected v=1 d=12345678 a=3 e=1",
                  out_valid, out_wr_data, out_wr_address, out_wr_enable);
      end
      drive_op(MEM_NONE, 32'h0, 32'h0, 32'h1234_5678, 5'd0, 1'b1);
      step();
      drive_idle();
      checks++;
      if ({out_valid, out_wr_enable} !== 2'b10) begin
         failures++;
         $display("FAIL pass_r0: got v=%b e=%b expected v=1 e=0", out_valid, out_wr_enable);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL pass_pulse: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      drive_op(MEM_NONE, 32'h0, 32'h0, 32'hA5A5_0001, 5'd4, 1'b1);
      step();
      drive_op(MEM_NONE, 32'h0, 32'h0, 32'h5A5A_0002, 5'd6, 1'b1);
      checks++;
      if ({out_valid, out_wr_data, out_wr_address, in_ready} !== {1'b1, 32'hA5A5_0001, 5'd4, 1'b1}) begin
         failures++;
         $display("FAIL b2b_first: got v=%b d=%h a=%0d rdy=%b expected v=1 d=a5a50001 a=4 rdy=1",
                  out_valid, out_wr_data, out_wr_address, in_ready);
      end
      step();
      drive_idle();
      checks++;
      if ({out_valid, out_wr_data, out_wr_address} !== {1'b1, 32'h5A5A_0002, 5'd6}) begin
         failures++;
         $display("FAIL b2b_second: got v=%b d=%h a=%0d expected v=1 d=5a5a0002 a=6",
                  out_valid, out_wr_data, out_wr_address);
      end
   endtask

   // Load with three wait cycles, then ack; rdata is held for the whole access.
   task automatic test_load(input string name, input mem_op_t op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp_addr,
                            input logic [31:0] exp_data);
      dm_if.dm_rdata = rdata;
      drive_op(op, addr, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1);
      step();
      drive_idle();
      checks++;
      if ({dm_if.dm_req, dm_if.dm_we, dm_if.dm_be, dm_if.dm_addr, in_ready} !== {1'b1, 1'b0, 4'hF, exp_addr, 1'b0}) begin
         failures++;
         $display("FAIL %s_req: got req=%b we=%b be=%h addr=%h rdy=%b expected req=1 we=0 be=f addr=%h rdy=0",
                  name, dm_if.dm_req, dm_if.dm_we, dm_if.dm_be, dm_if.dm_addr, in_ready, exp_addr);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({dm_if.dm_req, in_ready, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL %s_wait%0d: got req=%b rdy=%b v=%b expected req=1 rdy=0 v=0",
                     name, i, dm_if.dm_req, in_ready, out_valid);
         end
      end
      dm_if.dm_ack = 1'b1;
      step();
      dm_if.dm_ack = 1'b0;
      checks++;
      if ({out_valid, out_wr_data, out_wr_address, out_wr_enable, in_ready, dm_if.dm_req} !==
          {1'b1, exp_data, 5'd5, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL %s_done: got v=%b d=%h a=%0d e=%b rdy=%b req=%b expected v=1 d=%h a=5 e=1 rdy=1 req=0",
                  name, out_valid, out_wr_data, out_wr_address, out_wr_enable, in_ready, dm_if.dm_req, exp_data);
      end
   endtask

   task automatic test_store(input string name, input mem_op_t op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      drive_op(op, addr, sdata, 32'h0, 5'd7, 1'b1);
      step();
      drive_idle();
      checks++;
      if ({dm_if.dm_req, dm_if.dm_we, dm_if.dm_be, dm_if.dm_wdata, dm_if.dm_addr} !==
          {1'b1, 1'b1, exp_be, exp_wdata, exp_addr}) begin
         failures++;
         $display("FAIL %s_req: got req=%b we=%b be=%b wdata=%h addr=%h expected req=1 we=1 be=%b wdata=%h addr=%h",
                  name, dm_if.dm_req, dm_if.dm_we, dm_if.dm_be, dm_if.dm_wdata, dm_if.dm_addr,
                  exp_be, exp_wdata, exp_addr);
      end
      dm_if.dm_ack = 1'b1;
      step();
      dm_if.dm_ack = 1'b0;
      checks++;
      if ({out_valid, out_wr_enable, dm_if.dm_req, in_ready} !== 4'b1001) begin
         failures++;
         $display("FAIL %s_done: got v=%b e=%b req=%b rdy=%b expected v=1 e=0 req=0 rdy=1",
                  name, out_valid, out_wr_enable, dm_if.dm_req, in_ready);
      end
   endtask

   task automatic test_misaligned(input string name, input mem_op_t op, input logic [31:0] addr);
      drive_op(op, addr, 32'h0, 32'h0, 5'd8, 1'b1);
      step();
      drive_idle();
      checks++;
      if ({out_valid, out_wr_enable, exc_misaligned, exc_bus_err, dm_if.dm_req, in_ready} !== 6'b101001) begin
         failures++;
         $display("FAIL %s: got v=%b e=%b mis=%b bus=%b req=%b rdy=%b expected v=1 e=0 mis=1 bus=0 req=0 rdy=1",
                  name, out_valid, out_wr_enable, exc_misaligned, exc_bus_err, dm_if.dm_req, in_ready);
      end
      step();
      checks++;
      if ({exc_misaligned, out_valid} !== 2'b00) begin
         failures++;
         $display("FAIL %s_pulse: got mis=%b v=%b expected 0 0", name, exc_misaligned, out_valid);
      end
   endtask

   // With TIMEOUT=4 the bus error appears exactly 4 edges after dm_req rises.
   task automatic test_timeout();
      drive_op(LW, 32'h0000_0400, 32'h0, 32'h0, 5'd9, 1'b1);
      step();
      drive_idle();
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++;
         if ({dm_if.dm_req, exc_bus_err, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL timeout_wait%0d: got req=%b bus=%b v=%b expected req=1 bus=0 v=0",
                     k, dm_if.dm_req, exc_bus_err, out_valid);
         end
      end
      step();
      checks++;
      if ({dm_if.dm_req, exc_bus_err, out_valid, out_wr_enable, in_ready} !== 5'b01101) begin
         failures++;
         $display("FAIL timeout_fire: got req=%b bus=%b v=%b e=%b rdy=%b expected req=0 bus=1 v=1 e=0 rdy=1",
                  dm_if.dm_req, exc_bus_err, out_valid, out_wr_enable, in_ready);
      end
      dm_if.dm_ack = 1'b1;
      step();
      step();
      dm_if.dm_ack = 1'b0;
      checks++;
      if ({dm_if.dm_req, out_valid, exc_bus_err, in_ready} !== 4'b0001) begin
         failures++;
         $display("FAIL stray_ack: got req=%b v=%b bus=%b rdy=%b expected req=0 v=0 bus=0 rdy=1",
                  dm_if.dm_req, out_valid, exc_bus_err, in_ready);
      end
   endtask

   task automatic test_reset_mid_access();
      drive_op(LW, 32'h0000_0500, 32'h0, 32'h0, 5'd10, 1'b1);
      step();
      drive_idle();
      checks++;
      if (dm_if.dm_req !== 1'b1) begin
         failures++;
         $display("FAIL rst_access_req: got req=%b expected 1", dm_if.dm_req);
      end
      rst_n          = 1'b0;
      dm_if.dm_ack   = 1'b1;
      dm_if.dm_rdata = 32'h1111_2222;
      step();
      rst_n        = 1'b1;
      dm_if.dm_ack = 1'b0;
      checks++;
      if ({dm_if.dm_req, out_valid, out_wr_enable, in_ready} !== 4'b0001) begin
         failures++;
         $display("FAIL rst_access: got req=%b v=%b e=%b rdy=%b expected req=0 v=0 e=0 rdy=1",
                  dm_if.dm_req, out_valid, out_wr_enable, in_ready);
      end
      drive_op(MEM_NONE, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b1);
      step();
      drive_idle();
      checks++;
      if ({out_valid, out_wr_data, out_wr_address, out_wr_enable} !== {1'b1, 32'hCAFE_F00D, 5'd9, 1'b1}) begin
         failures++;
         $display("FAIL rst_after: got v=%b d=%h a=%0d e=%b expected v=1 d=cafef00d a=9 e=1",
                  out_valid, out_wr_data, out_wr_address, out_wr_enable);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_back_to_back();
      test_load("lb",  LB,  32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 32'hFFFF_FF80);
      test_load("lbu", LBU, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 32'h0000_0080);
      test_load("lh",  LH,  32'h0000_0302, 32'h8001_1234, 32'h0000_0300, 32'hFFFF_8001);
      test_load("lhu", LHU, 32'h0000_0300, 32'h8001_F234, 32'h0000_0300, 32'h0000_F234);
      test_load("lw",  LW,  32'h0000_0304, 32'h1357_9BDF, 32'h0000_0304, 32'h1357_9BDF);
      test_store("sh", SH, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
      test_store("sb", SB, 32'h0000_0101, 32'h1234_565A, 32'h0000_0100, 4'b0010, 32'h5A5A_5A5A);
      test_store("sw", SW, 32'h0000_0208, 32'hC001_D00D, 32'h0000_0208, 4'b1111, 32'hC001_D00D);
      test_misaligned("mis_lw", LW, 32'h0000_0301);
      test_misaligned("mis_sh", SH, 32'h0000_0103);
      test_timeout();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "bench timed out");
   end
endmodule
